pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Program-counter stage feeding the combinational adder. Holds the fetch PC, drives
//  it and a constant step to the adder's Ain/Bin, and registers add_out as the next
//  sequential PC. Handles stall, branch redirect, halt and address wrap. Offers each
//  PC to instruction memory over a valid/ready handshake; counts accepted fetches.
// PARAMETERS
//  W        `WORD   datapath/address width; matches adder width
//  STEP     1       increment driven on adder Bin (word-addressed IMEM)
//  RESET_PC 0       PC value loaded on reset
//  CNT_W    32      width of fetch_count
// PORTS
//  clk           in   1      rising-edge clock
//  rst           in   1      synchronous, active-high reset
//  add_a         out  W      to adder Ain; always equals pc
//  add_b         out  W      to adder Bin; constant STEP
//  add_sum       in   W      from adder add_out (pc+STEP, mod 2^W, same cycle)
//  pc            out  W      current fetch address
//  pc_valid      out  1      pc is a live fetch request
//  imem_ready    in   1      IMEM accepts pc this cycle
//  stall         in   1      hold pc; no advance
//  branch_valid  in   1      redirect to branch_target
//  branch_target in   W      redirect address
//  halt          in   1      stop fetching
//  halted        out  1      in HALTED state
//  fault         out  1      sticky: wrap or misaligned target
//  fetch_count   out  CNT_W  accepted fetches, saturating
// BEHAVIOUR
//  Reset (rst=1 at edge): state=BOOT, pc=RESET_PC, pc_valid=0, halted=0, fault=0,
//   fetch_count=0. rst overrides every other input in any state, mid-operation too.
//  States: BOOT -> RUN (unconditional, next edge); RUN -> HALTED; HALTED exits only via rst.
//  BOOT: pc_valid=0; one idle cycle after reset release.
//  RUN: pc_valid=1. fire = pc_valid & imem_ready. Per-edge priority, highest first:
//   1 halt=1           -> HALTED; pc frozen; fire this cycle still counted.
//   2 branch_valid=1   -> pc<=branch_target; overrides stall/ready. If STEP is a power
//                         of two and target low log2(STEP) bits !=0 -> fault<=1, HALTED.
//   3 stall=1          -> pc held.
//   4 fire & !stall    -> pc<=add_sum; if add_sum<pc (unsigned wrap) -> pc<=add_sum,
//                         fault<=1, HALTED.
//   5 otherwise        -> pc held (valid stays high until ready).
//  Handshake: pc stable while pc_valid & !imem_ready, except on branch redirect
//   (request discarded by design). Latency: accepted fetch -> next pc one cycle later.
//  fetch_count: +1 on every fire in RUN (incl. stalled, branched, halting cycles);
//   saturates at 2^CNT_W-1, never wraps.
//  HALTED: pc_valid=0, halted=1; branch/stall/ready ignored; pc, fault, fetch_count frozen.
//  add_a/add_b purely combinational from pc/STEP; no other output combinational from inputs.
// TESTING
//  T1 reset: rst 2 cycles -> pc=0, pc_valid=0 one cycle, then pc_valid=1, count=0.
//  T2 stream: imem_ready=1 x4 from pc=0 -> pc 1,2,3,4; fetch_count=4.
//  T3 backpressure/stall: ready=0 3 cycles, then stall=1,ready=1 2 cycles -> pc held
//     at 4; count +2 from stalled fires only; pc=5 after stall drops.
//  T4 branch: branch_valid=1,target=1023 with stall=1,ready=0 -> pc=1023 next edge;
//     one fire -> pc=1024 (carry across bit 10). Same cycle halt=1 -> halt wins, pc kept.
//  T5 wrap: branch to 2^W-2 (W=42: 4398046511102), ready=1 -> 4398046511103, then
//     next fire -> pc=0, fault=1, halted=1, pc_valid=0; further stimulus no effect.
//  T6 rst mid-run and in HALTED -> full reset values next edge; fault cleared.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter stage in front of an external combinational adder.
// It holds the fetch PC and drives that PC and a constant step into the adder.
// The adder's sum is registered as the next sequential PC.
// Stall, branch redirect, halt and address wrap are handled here.
// Each PC is offered to instruction memory and accepted fetches are counted.
//
// Handshake: pc is a request whenever pc_valid=1, and it is taken on a rising
// edge where pc_valid & imem_ready (a "fire"). While pc_valid & !imem_ready the
// pc is held stable. The one exception is a branch redirect, which discards the
// pending request by design. An accepted fetch shows its successor pc one
// cycle later.
module pc_sequencer #(
  parameter int W        = 42,
  parameter int STEP     = 1,
  parameter int RESET_PC = 0,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic [W-1:0]     add_a,
  output logic [W-1:0]     add_b,
  input  logic [W-1:0]     add_sum,
  output logic [W-1:0]     pc,
  output logic             pc_valid,
  input  logic             imem_ready,
  input  logic             stall,
  input  logic             branch_valid,
  input  logic [W-1:0]     branch_target,
  input  logic             halt,
  output logic             halted,
  output logic             fault,
  output logic [CNT_W-1:0] fetch_count,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam bit               STEP_POW2  = (STEP > 0) && ((STEP & (STEP - 1)) == 0);
  localparam logic [W-1:0]     ALIGN_MASK = W'(STEP - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [W-1:0]     r_pc;
  logic [W-1:0]     w_pc_nxt;
  logic             r_fault;
  logic             w_fault_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_fire;
  logic             w_misaligned;
  logic             w_wrap;

  // Handshake and exception detection for the current cycle.
  always_comb begin
    w_fire       = (r_state == ST_RUN) && imem_ready;
    w_misaligned = STEP_POW2 && ((branch_target & ALIGN_MASK) != '0);
    w_wrap       = (add_sum < r_pc);
  end

  // Next-state, next-pc, fault and fetch counter; halt > branch > stall > fire.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_fault_nxt = r_fault;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_BOOT: begin
        w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        // Every fire is counted, even on stall, branch or halt cycles.
        if (w_fire && (r_cnt != CNT_MAX)) begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
        if (halt) begin
          w_state_nxt = ST_HALTED;
        end else if (branch_valid) begin
          w_pc_nxt = branch_target;
          if (w_misaligned) begin
            w_fault_nxt = 1'b1;
            w_state_nxt = ST_HALTED;
          end
        end else if (stall) begin
          w_pc_nxt = r_pc;
        end else if (w_fire) begin
          w_pc_nxt = add_sum;
          if (w_wrap) begin
            w_fault_nxt = 1'b1;
            w_state_nxt = ST_HALTED;
          end
        end
      end
      ST_HALTED: begin
        w_state_nxt = ST_HALTED;
      end
      default: begin
        w_state_nxt = ST_BOOT;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_BOOT;
      r_pc    <= W'(RESET_PC);
      r_fault <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_fault <= w_fault_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Outputs are registered values only, except the adder operands.
  always_comb begin
    add_a       = r_pc;
    add_b       = W'(STEP);
    pc          = r_pc;
    pc_valid    = (r_state == ST_RUN);
    halted      = (r_state == ST_HALTED);
    fault       = r_fault;
    fetch_count = r_cnt;
    dbg_state   = r_state;
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer: directed scenarios followed by randomized stimulus.
// Every cycle is checked against a behavioural reference model.
module tb_pc_sequencer;

  localparam int W        = 42;
  localparam int STEP     = 1;
  localparam int RESET_PC = 0;
  localparam int CNT_W    = 5;

  localparam longint unsigned PC_MOD  = 64'd1 << W;
  localparam longint unsigned CNT_TOP = (64'd1 << CNT_W) - 1;

  logic             clk;
  logic             rst;
  logic [W-1:0]     add_a;
  logic [W-1:0]     add_b;
  logic [W-1:0]     add_sum;
  logic [W-1:0]     pc;
  logic             pc_valid;
  logic             imem_ready;
  logic             stall;
  logic             branch_valid;
  logic [W-1:0]     branch_target;
  logic             halt;
  logic             halted;
  logic             fault;
  logic [CNT_W-1:0] fetch_count;
  logic [1:0]       dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state.
  logic             m_booting;
  logic             m_stopped;
  longint unsigned  m_pc;
  logic             m_fault;
  longint unsigned  m_cnt;

  // Expected fetch count recorded at the end of each directed scenario.
  logic [63:0] exp_q[$];

  pc_sequencer #(
    .W(W), .STEP(STEP), .RESET_PC(RESET_PC), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
    .pc(pc), .pc_valid(pc_valid), .imem_ready(imem_ready), .stall(stall),
    .branch_valid(branch_valid), .branch_target(branch_target), .halt(halt),
    .halted(halted), .fault(fault), .fetch_count(fetch_count),
    .dbg_state(dbg_state)
  );

  // The external adder that sits next to the sequencer.
  assign add_sum = add_a + add_b;

  // Clock generation.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: advance one clock edge using the inputs currently applied.
  task automatic model_edge();
    longint unsigned nxt;
    if (rst) begin
      m_booting = 1'b1;
      m_stopped = 1'b0;
      m_pc      = RESET_PC;
      m_fault   = 1'b0;
      m_cnt     = 0;
    end else if (m_booting) begin
      m_booting = 1'b0;
    end else if (!m_stopped) begin
      if (imem_ready && m_cnt < CNT_TOP) m_cnt = m_cnt + 1;
      if (halt) begin
        m_stopped = 1'b1;
      end else if (branch_valid) begin
        m_pc = branch_target;
        if ((STEP & (STEP - 1)) == 0 && (m_pc % STEP) != 0) begin
          m_fault   = 1'b1;
          m_stopped = 1'b1;
        end
      end else if (!stall && imem_ready) begin
        nxt = (m_pc + STEP) % PC_MOD;
        if (nxt < m_pc) begin
          m_fault   = 1'b1;
          m_stopped = 1'b1;
        end
        m_pc = nxt;
      end
    end
  endtask

  task automatic compare_all();
    check("pc", 64'(pc), m_pc);
    check("pc_valid", 64'(pc_valid), 64'(!m_booting && !m_stopped));
    check("halted", 64'(halted), 64'(m_stopped));
    check("fault", 64'(fault), 64'(m_fault));
    check("fetch_count", 64'(fetch_count), m_cnt);
    check("add_a", 64'(add_a), m_pc);
    check("add_b", 64'(add_b), 64'(STEP));
  endtask

  // One clock: update the model, take the edge, then compare 1 ns later.
  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic drive(input logic r, input logic rdy, input logic stl,
                       input logic br, input longint unsigned tgt, input logic hlt);
    rst           = r;
    imem_ready    = rdy;
    stall         = stl;
    branch_valid  = br;
    branch_target = W'(tgt);
    halt          = hlt;
  endtask

  task automatic reset_and_boot();
    drive(1, 0, 0, 0, 0, 0);
    tick();
    tick();
    drive(0, 0, 0, 0, 0, 0);
    tick();
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0);
    m_booting = 1'b1; m_stopped = 1'b0; m_pc = 0; m_fault = 1'b0; m_cnt = 0;
    @(negedge clk);

    // T1 reset: two reset cycles, one idle cycle, then a live request.
    tick();
    tick();
    check("t1_pc_rst", 64'(pc), 64'd0);
    check("t1_valid_rst", 64'(pc_valid), 64'd0);
    drive(0, 0, 0, 0, 0, 0);
    tick();
    check("t1_valid_run", 64'(pc_valid), 64'd1);
    check("t1_count", 64'(fetch_count), 64'd0);

    // T2 streaming fetches.
    for (int i = 1; i <= 4; i++) begin
      drive(0, 1, 0, 0, 0, 0);
      tick();
      check("t2_pc", 64'(pc), 64'(i));
    end
    check("t2_count", 64'(fetch_count), 64'd4);
    exp_q.push_back(64'd4);

    // T3 backpressure then stall.
    drive(0, 0, 0, 0, 0, 0);
    repeat (3) tick();
    drive(0, 1, 1, 0, 0, 0);
    repeat (2) tick();
    check("t3_pc_held", 64'(pc), 64'd4);
    check("t3_count", 64'(fetch_count), 64'd6);
    drive(0, 1, 0, 0, 0, 0);
    tick();
    check("t3_pc_adv", 64'(pc), 64'd5);
    exp_q.push_back(64'd7);

    // T4 branch over stall/backpressure, carry, then halt beats branch.
    drive(0, 0, 1, 1, 1023, 0);
    tick();
    check("t4_branch", 64'(pc), 64'd1023);
    drive(0, 1, 0, 0, 0, 0);
    tick();
    check("t4_carry", 64'(pc), 64'd1024);
    drive(0, 1, 0, 1, 5, 1);
    tick();
    check("t4_halt_pc", 64'(pc), 64'd1024);
    check("t4_halted", 64'(halted), 64'd1);
    exp_q.push_back(64'd9);
    drive(0, 1, 0, 1, 77, 0);
    repeat (3) tick();
    check("t4_frozen_count", 64'(fetch_count), exp_q[$]);

    // T6a reset while halted.
    reset_and_boot();
    check("t6_halted_rst", 64'(fetch_count), 64'd0);

    // T5 wrap at the top of the address space.
    drive(0, 1, 0, 1, PC_MOD - 2, 0);
    tick();
    check("t5_target", 64'(pc), PC_MOD - 2);
    drive(0, 1, 0, 0, 0, 0);
    tick();
    check("t5_top", 64'(pc), 64'd4398046511103);
    tick();
    check("t5_wrap_pc", 64'(pc), 64'd0);
    check("t5_fault", 64'(fault), 64'd1);
    check("t5_valid", 64'(pc_valid), 64'd0);
    for (int i = 0; i < 6; i++) begin
      drive(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            $urandom_range(0, 4095), 1'($urandom_range(0, 1)));
      tick();
    end
    check("t5_stuck_pc", 64'(pc), 64'd0);

    // T6b reset from fault, then reset in the middle of streaming.
    reset_and_boot();
    check("t6_fault_clr", 64'(fault), 64'd0);
    drive(0, 1, 0, 0, 0, 0);
    repeat (3) tick();
    drive(1, 1, 0, 1, 99, 0);
    tick();
    check("t6_mid_pc", 64'(pc), 64'd0);
    check("t6_mid_count", 64'(fetch_count), 64'd0);
    drive(0, 0, 0, 0, 0, 0);
    tick();

    // Randomized phase, including counter saturation and wrap/branch corners.
    for (int i = 0; i < 3000; i++) begin
      longint unsigned tgt;
      case ($urandom_range(0, 3))
        0: tgt = {$urandom, $urandom} % PC_MOD;
        1: tgt = PC_MOD - 1;
        2: tgt = PC_MOD - 2 - $urandom_range(0, 3);
        default: tgt = $urandom_range(0, 64);
      endcase
      drive($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 30,
            $urandom_range(0, 99) < 10, tgt, $urandom_range(0, 99) < 2);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
